// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generator issuing over a req/gnt/rvalid memory port, feeding a
// DEPTH-entry {instr, pc} queue that decode drains via valid/ready; redirects flush and squash stale data.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  input  logic        instr_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] inflight_after_resp;
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   redirect_addr;
  logic [CW:0]   credit_used;
  logic          issue;
  logic          push;
  logic          pop;
  entry_t        head;

  assign redirect_addr       = {redirect_pc[31:2], 2'b00};
  assign inflight_after_resp = inflight - CW'(imem_rvalid);

  // Credit: queued entries plus outstanding requests never exceed DEPTH, so pushes always fit.
  assign credit_used = {1'b0, count} + {1'b0, inflight};
  assign imem_req    = reset & ~redirect & (credit_used < DEPTH_W);
  assign imem_addr   = fetch_pc;
  assign issue       = imem_req & imem_gnt;

  assign push        = imem_rvalid & ~redirect & (drop_cnt == '0);
  assign instr_valid = (count != '0);
  assign pop         = instr_valid & instr_ready;

  assign head  = mem[rd_ptr];
  assign instr = instr_valid ? head.instr : 32'h0;
  assign pc    = instr_valid ? head.pc : resp_pc;
  assign pc4   = pc + 32'd4;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      drop_cnt <= '0;
    end else if (redirect) begin
      // Every request still outstanding after this cycle belongs to the old path.
      fetch_pc <= redirect_addr;
      resp_pc  <= redirect_addr;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= inflight_after_resp;
      drop_cnt <= inflight_after_resp;
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (push) begin
        wr_ptr  <= wr_ptr + PW'(1);
        resp_pc <= resp_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count    <= count + CW'(push) - CW'(pop);
      inflight <= inflight_after_resp + CW'(issue);
      if (imem_rvalid && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{instr: imem_rdata, pc: resp_pc};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order variable-latency memory model plus an expected-entry scoreboard.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        instr_ready;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc          (pc),
    .pc4         (pc4),
    .instr_ready (instr_ready)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } req_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  req_t        pend[$];
  ent_t        sb[$];
  logic [31:0] seen_pc[$];
  logic [31:0] seen_instr[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          rel_cyc = 0;
  int          first_valid = -1;
  int          n_pops = 0;
  int          epoch = 0;
  int          lat = 1;
  int          last_due = -1;
  logic [31:0] exp_fetch = RESET_PC;
  logic [31:0] exp_resp = RESET_PC;
  logic [31:0] a0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: memory drives its response, outputs are checked, handshakes update the model.
  task automatic step();
    req_t        r;
    logic        resp_now;
    logic        sb_nonempty;
    logic [31:0] hpc;
    int          d;
    resp_now = 1'b0;
    r = '{32'h0, 0, 0};
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      resp_now = 1'b1;
    end
    imem_rvalid = resp_now;
    imem_rdata  = resp_now ? mem_word(r.addr) : 32'hDEAD_BEEF;
    #1;
    sb_nonempty = (sb.size() != 0);
    hpc = sb_nonempty ? sb[0].pc : exp_resp;
    chk_eq("instr_valid", 32'(instr_valid), 32'(sb_nonempty));
    chk_eq("head_pc", pc, hpc);
    chk_eq("head_pc4", pc4, hpc + 32'd4);
    chk_eq("head_instr", instr, sb_nonempty ? sb[0].instr : 32'h0);
    chk_eq("imem_addr", imem_addr, exp_fetch);
    chk_eq("imem_req", 32'(imem_req),
           32'(!redirect && ((sb.size() + pend.size() + int'(resp_now)) < DEPTH)));
    if (instr_valid && first_valid < 0) first_valid = cyc - rel_cyc;
    if (instr_valid && instr_ready) begin
      seen_pc.push_back(pc);
      seen_instr.push_back(instr);
      n_pops++;
      if (sb_nonempty) sb.delete(0);
    end
    if (resp_now && !redirect && r.epoch == epoch) begin
      sb.push_back('{mem_word(exp_resp), exp_resp});
      exp_resp += 32'd4;
    end
    if (imem_req && imem_gnt) begin
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      pend.push_back('{imem_addr, d, epoch});
      exp_fetch += 32'd4;
    end
    if (redirect) begin
      sb.delete();
      epoch++;
      exp_fetch = {redirect_pc[31:2], 2'b00};
      exp_resp  = exp_fetch;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Asserts reset between clock edges, checks outputs respond at once, releases after two edges.
  task automatic do_reset();
    #2;
    reset = 1'b0;
    #1;
    chk_eq("rst_valid", 32'(instr_valid), 32'h0);
    chk_eq("rst_req", 32'(imem_req), 32'h0);
    chk_eq("rst_pc", pc, RESET_PC);
    chk_eq("rst_pc4", pc4, RESET_PC + 32'd4);
    chk_eq("rst_instr", instr, 32'h0);
    chk_eq("rst_addr", imem_addr, RESET_PC);
    pend.delete();
    sb.delete();
    seen_pc.delete();
    seen_instr.delete();
    epoch++;
    last_due    = -1;
    exp_fetch   = RESET_PC;
    exp_resp    = RESET_PC;
    imem_rvalid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk_eq("rst_hold_req", 32'(imem_req), 32'h0);
    reset       = 1'b1;
    rel_cyc     = cyc;
    first_valid = -1;
    n_pops      = 0;
  endtask

  initial begin
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
    do_reset();

    // Streaming from reset: 1-cycle memory, decode always ready.
    imem_gnt = 1'b1; instr_ready = 1'b1; lat = 1;
    repeat (12) step();
    chk_eq("first_valid_cycle", 32'(first_valid), 32'd2);
    chk_eq("stream_pops", 32'(n_pops), 32'd10);
    for (int i = 0; i < 4; i++) chk_eq("stream_pc", seen_pc[i], RESET_PC + 32'(4 * i));
    chk_eq("stream_instr0", seen_instr[0], mem_word(RESET_PC));

    // Asynchronous reset mid-stream, then backpressure from the restart.
    do_reset();
    instr_ready = 1'b0;
    repeat (10) step();
    chk_eq("bp_req_off", 32'(imem_req), 32'h0);
    chk_eq("bp_valid", 32'(instr_valid), 32'h1);
    chk_eq("bp_head_pc", pc, RESET_PC);
    instr_ready = 1'b1;
    repeat (6) step();
    for (int i = 0; i < 4; i++) chk_eq("bp_drain_pc", seen_pc[i], RESET_PC + 32'(4 * i));

    // Grant stall: request and address held, queue drains and nothing new arrives.
    a0 = exp_fetch;
    imem_gnt = 1'b0;
    repeat (5) step();
    chk_eq("stall_addr", imem_addr, a0);
    chk_eq("stall_req", 32'(imem_req), 32'h1);
    chk_eq("stall_empty", 32'(instr_valid), 32'h0);

    // Redirect with two requests outstanding at 3-cycle latency.
    lat = 3; imem_gnt = 1'b1;
    repeat (2) step();
    imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_4002;
    step();
    redirect = 1'b0; imem_gnt = 1'b1;
    seen_pc.delete(); seen_instr.delete();
    repeat (12) step();
    chk_eq("redir_first_pc", seen_pc[0], 32'h0000_4000);
    chk_eq("redir_first_instr", seen_instr[0], mem_word(32'h0000_4000));
    chk_eq("redir_second_pc", seen_pc[1], 32'h0000_4004);

    // Redirect coinciding with rvalid and pop, followed by a second redirect next cycle.
    lat = 1;
    repeat (4) step();
    redirect = 1'b1; redirect_pc = 32'h0000_5000;
    step();
    chk_eq("redir_queue_empty", 32'(instr_valid), 32'h0);
    redirect_pc = 32'h0000_6000;
    step();
    redirect = 1'b0;
    seen_pc.delete(); seen_instr.delete();
    repeat (10) step();
    chk_eq("b2b_first_pc", seen_pc[0], 32'h0000_6000);
    chk_eq("b2b_second_pc", seen_pc[1], 32'h0000_6004);

    // Redirect, one request issued on the new path, then redirected again before it returns.
    redirect = 1'b1; redirect_pc = 32'h0000_7000;
    step();
    redirect = 1'b0; lat = 2;
    step();
    redirect = 1'b1; redirect_pc = 32'h0000_7101;
    step();
    redirect = 1'b0;
    seen_pc.delete(); seen_instr.delete();
    repeat (10) step();
    chk_eq("squash_first_pc", seen_pc[0], 32'h0000_7100);
    chk_eq("squash_first_instr", seen_instr[0], mem_word(32'h0000_7100));

    // Random traffic: grant, ready, latency and occasional redirects.
    repeat (400) begin
      imem_gnt    = ($urandom_range(0, 3) != 0);
      instr_ready = ($urandom_range(0, 9) < 7);
      lat         = $urandom_range(1, 4);
      redirect    = ($urandom_range(0, 31) == 0);
      redirect_pc = $urandom;
      step();
    end
    redirect = 1'b0;
    imem_gnt = 1'b0;
    instr_ready = 1'b1;
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
